// File: rtl/rv_id_stage.sv
// RV32I instruction-decode stage: decodes OP/OP-IMM/LUI, reads the 32x32 register
// file with writeback bypass, and holds one decoded instruction for rv_alu.
module rv_id_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      op_out,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            illegal,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_OR   = 4'd9;
  localparam logic [3:0] ALU_AND  = 4'd10;

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
    logic signed [11:0] s;
    s = imm;
    return XLEN'(s);
  endfunction

  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0] opc_p0;
  logic [6:0] f7_p0;
  logic [2:0] f3_p0;
  logic [4:0] rs1_a_p0;
  logic [4:0] rs2_a_p0;
  logic [4:0] rd_a_p0;

  assign opc_p0   = instr[6:0];
  assign rd_a_p0  = instr[11:7];
  assign f3_p0    = instr[14:12];
  assign rs1_a_p0 = instr[19:15];
  assign rs2_a_p0 = instr[24:20];
  assign f7_p0    = instr[31:25];

  logic [XLEN-1:0] rf [32];

  logic [3:0]      op_p0;
  logic            ill_p0;
  logic            use_rs1_p0;
  logic            use_rs2_p0;
  logic [XLEN-1:0] imm_p0;
  logic            we_p0;

  always_comb begin
    op_p0      = ALU_NOP;
    ill_p0     = 1'b1;
    use_rs1_p0 = 1'b0;
    use_rs2_p0 = 1'b0;
    imm_p0     = '0;
    case (opc_p0)
      OPC_OP: begin
        use_rs1_p0 = 1'b1;
        use_rs2_p0 = 1'b1;
        if (f7_p0 == F7_BASE) begin
          ill_p0 = 1'b0;
          op_p0  = base_op(f3_p0);
        end else if (f7_p0 == F7_ALT && f3_p0 == 3'b000) begin
          ill_p0 = 1'b0;
          op_p0  = ALU_SUB;
        end else if (f7_p0 == F7_ALT && f3_p0 == 3'b101) begin
          ill_p0 = 1'b0;
          op_p0  = ALU_SRA;
        end
      end
      OPC_OPIMM: begin
        use_rs1_p0 = 1'b1;
        if (f3_p0 == 3'b001 || f3_p0 == 3'b101) begin
          // Shifts take a 5-bit shamt; the upper bits only select logical vs arithmetic.
          imm_p0 = XLEN'(rs2_a_p0);
          if (f7_p0 == F7_BASE) begin
            ill_p0 = 1'b0;
            op_p0  = base_op(f3_p0);
          end else if (f7_p0 == F7_ALT && f3_p0 == 3'b101) begin
            ill_p0 = 1'b0;
            op_p0  = ALU_SRA;
          end
        end else begin
          imm_p0 = sext12(instr[31:20]);
          ill_p0 = 1'b0;
          op_p0  = base_op(f3_p0);
        end
      end
      OPC_LUI: begin
        ill_p0 = 1'b0;
        op_p0  = ALU_ADD;
        imm_p0 = XLEN'({instr[31:12], 12'b0});
      end
      default: ;
    endcase
  end

  assign we_p0 = !ill_p0 && (rd_a_p0 != 5'd0);

  // Register reads see a same-cycle writeback so the consumer never gets a stale value.
  logic [XLEN-1:0] rs1_rd_p0;
  logic [XLEN-1:0] rs2_rd_p0;
  logic [XLEN-1:0] a_p0;
  logic [XLEN-1:0] b_p0;
  logic [4:0]      src1_p0;
  logic [4:0]      src2_p0;
  logic            wb_hit;

  assign wb_hit    = wb_we && (wb_addr != 5'd0);
  assign rs1_rd_p0 = (rs1_a_p0 == 5'd0) ? '0 :
                     (wb_hit && wb_addr == rs1_a_p0) ? wb_data : rf[rs1_a_p0];
  assign rs2_rd_p0 = (rs2_a_p0 == 5'd0) ? '0 :
                     (wb_hit && wb_addr == rs2_a_p0) ? wb_data : rf[rs2_a_p0];
  assign a_p0      = use_rs1_p0 ? rs1_rd_p0 : '0;
  assign b_p0      = use_rs2_p0 ? rs2_rd_p0 : imm_p0;
  assign src1_p0   = (use_rs1_p0 && !ill_p0) ? rs1_a_p0 : 5'd0;
  assign src2_p0   = (use_rs2_p0 && !ill_p0) ? rs2_a_p0 : 5'd0;

  // ---- stage boundary: p0 decode -> p1 output register ----
  logic            vld_p1;
  logic [3:0]      op_p1;
  logic [XLEN-1:0] a_p1;
  logic [XLEN-1:0] b_p1;
  logic [4:0]      rd_p1;
  logic            we_p1;
  logic            ill_p1;
  logic [4:0]      src1_p1;
  logic [4:0]      src2_p1;
  logic            accept;

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      op_p1   <= ALU_NOP;
      a_p1    <= '0;
      b_p1    <= '0;
      rd_p1   <= 5'd0;
      we_p1   <= 1'b0;
      ill_p1  <= 1'b0;
      src1_p1 <= 5'd0;
      src2_p1 <= 5'd0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (wb_hit) rf[wb_addr] <= wb_data;
      if (accept) begin
        vld_p1  <= 1'b1;
        op_p1   <= op_p0;
        a_p1    <= a_p0;
        b_p1    <= b_p0;
        rd_p1   <= rd_a_p0;
        we_p1   <= we_p0;
        ill_p1  <= ill_p0;
        src1_p1 <= src1_p0;
        src2_p1 <= src2_p0;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end else if (vld_p1 && wb_hit) begin
        // Stalled: keep held register operands coherent with later writebacks.
        if (src1_p1 == wb_addr) a_p1 <= wb_data;
        if (src2_p1 == wb_addr) b_p1 <= wb_data;
      end
    end
  end

  assign out_valid = vld_p1;
  assign op_out    = op_p1;
  assign rs1_val   = a_p1;
  assign rs2_val   = b_p1;
  assign rd_addr   = rd_p1;
  assign rd_we     = we_p1;
  assign illegal   = ill_p1;

endmodule

// File: tb/tb_rv_id_stage.sv
// Directed bench for rv_id_stage: a behavioural decode/register-file model checked
// every cycle, plus literal expectations for the hand-computed vectors.
module tb_rv_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  op_out;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        illegal;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  rv_id_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .op_out(op_out),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr), .rd_we(rd_we),
    .illegal(illegal), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural register state plus what the output must hold.
  int          base_op [8] = '{1, 3, 4, 5, 6, 7, 9, 10};
  logic [31:0] mrf [32];
  logic        mstarted = 1'b0;
  logic        clean;
  logic        exp_valid;
  logic [3:0]  exp_op;
  logic [31:0] exp_a, exp_b;
  logic [4:0]  exp_rd, h1, h2;
  logic        exp_we, exp_ill;

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wb_we && wb_addr == a) return wb_data;
    return mrf[a];
  endfunction

  task automatic mdecode(input logic [31:0] ins);
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3  = ins[14:12];
    logic [6:0] f7  = ins[31:25];
    logic [4:0] r1  = ins[19:15];
    logic [4:0] r2  = ins[24:20];
    logic       shift = (f3 == 3'd1) || (f3 == 3'd5);
    exp_ill = 1'b1; exp_op = 4'd0; exp_a = 0; exp_b = 0; h1 = 0; h2 = 0;
    exp_rd = ins[11:7];
    if (opc == 7'h33) begin
      if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
        exp_ill = 1'b0;
        exp_op  = (f7 == 7'h20) ? ((f3 == 3'd0) ? 4'd2 : 4'd8) : 4'(base_op[f3]);
        exp_a = mread(r1); exp_b = mread(r2); h1 = r1; h2 = r2;
      end
    end else if (opc == 7'h13) begin
      if (!shift || f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20)) begin
        exp_ill = 1'b0;
        exp_op  = (f3 == 3'd5 && f7 == 7'h20) ? 4'd8 : 4'(base_op[f3]);
        exp_a = mread(r1); h1 = r1;
        exp_b = shift ? {27'd0, ins[24:20]} : {{20{ins[31]}}, ins[31:20]};
      end
    end else if (opc == 7'h37) begin
      exp_ill = 1'b0; exp_op = 4'd1; exp_b = {ins[31:12], 12'd0};
    end
    exp_we = !exp_ill && exp_rd != 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mstarted = 1'b1; clean = 1'b1; exp_valid = 1'b0;
      exp_op = 0; exp_a = 0; exp_b = 0; exp_rd = 0; exp_we = 0; exp_ill = 0; h1 = 0; h2 = 0;
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    end else if (mstarted) begin
      if (in_valid && (!exp_valid || out_ready)) begin
        mdecode(instr); exp_valid = 1'b1; clean = 1'b0;
      end else if (out_ready) begin
        exp_valid = 1'b0;
      end else if (exp_valid && wb_we && wb_addr != 0) begin
        if (h1 == wb_addr) exp_a = wb_data;
        if (h2 == wb_addr) exp_b = wb_data;
      end
      if (wb_we && wb_addr != 0) mrf[wb_addr] = wb_data;
    end
  end

  always @(negedge clk) begin
    if (mstarted) begin
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("in_ready", 32'(in_ready), 32'(!exp_valid || out_ready));
      if (exp_valid || clean) begin
        chk("op_out", 32'(op_out), 32'(exp_op));
        chk("illegal", 32'(illegal), 32'(exp_ill));
        chk("rd_we", 32'(rd_we), 32'(exp_we));
        if (!exp_ill) begin
          chk("rd_addr", 32'(rd_addr), 32'(exp_rd));
          chk("rs1_val", rs1_val, exp_a);
          chk("rs2_val", rs2_val, exp_b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    in_valid = 1'b1; out_ready = 1'b1; instr = ins;
    tick();
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    in_valid = 1'b0; wb_we = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = 32'd0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    tick(); tick();
    rst = 1'b0;
    chk("lit_rst_valid", 32'(out_valid), 32'd0);
    chk("lit_rst_ready", 32'(in_ready), 32'd1);

    // addi x1,x0,2 then lui x1,0x12345
    issue(32'h00200093);
    chk("lit_addi_op", 32'(op_out), 32'd1);
    chk("lit_addi_a", rs1_val, 32'd0);
    chk("lit_addi_b", rs2_val, 32'd2);
    chk("lit_addi_rd", 32'(rd_addr), 32'd1);
    chk("lit_addi_we", 32'(rd_we), 32'd1);
    issue(32'h123450B7);
    chk("lit_lui_b", rs2_val, 32'h12345000);
    chk("lit_lui_op", 32'(op_out), 32'd1);

    // sub x4,x2,x3 with and without same-cycle bypass
    out_ready = 1'b1;
    wb(5'd2, 32'd5);
    wb(5'd3, 32'd7);
    issue(32'h40310233);
    chk("lit_sub_op", 32'(op_out), 32'd2);
    chk("lit_sub_a", rs1_val, 32'd5);
    chk("lit_sub_b", rs2_val, 32'd7);
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'd9;
    issue(32'h40310233);
    wb_we = 1'b0;
    chk("lit_byp_b", rs2_val, 32'd9);

    // add x5,x2,x3 then stall with a blocked instruction waiting
    issue(32'h003102B3);
    out_ready = 1'b0; instr = 32'h40310233;
    tick();
    chk("lit_stall_ready", 32'(in_ready), 32'd0);
    chk("lit_stall_a", rs1_val, 32'd5);
    chk("lit_stall_b", rs2_val, 32'd9);
    tick();
    chk("lit_stall_op", 32'(op_out), 32'd1);
    wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'hAA;
    tick();
    wb_we = 1'b0;
    chk("lit_holdfwd_a", rs1_val, 32'hAA);
    chk("lit_holdfwd_b", rs2_val, 32'd9);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("lit_drain_valid", 32'(out_valid), 32'd0);

    // back-to-back: addi x6,x0,-1; or x7,x2,x3; srai x8,x2,3; sltu x9,x2,x3
    issue(32'hFFF00313);
    chk("lit_b2b0_b", rs2_val, 32'hFFFFFFFF);
    issue(32'h003163B3);
    chk("lit_b2b1_op", 32'(op_out), 32'd9);
    issue(32'h40315413);
    chk("lit_b2b2_op", 32'(op_out), 32'd8);
    chk("lit_b2b2_b", rs2_val, 32'd3);
    issue(32'h003134B3);
    chk("lit_b2b3_op", 32'(op_out), 32'd5);
    chk("lit_b2b3_valid", 32'(out_valid), 32'd1);

    // illegal major opcode, bad srai funct7, add x0, and x0 write
    issue(32'h0000007F);
    chk("lit_ill0_ill", 32'(illegal), 32'd1);
    chk("lit_ill0_op", 32'(op_out), 32'd0);
    chk("lit_ill0_we", 32'(rd_we), 32'd0);
    issue(32'h02315413);
    chk("lit_ill1_ill", 32'(illegal), 32'd1);
    chk("lit_ill1_we", 32'(rd_we), 32'd0);
    issue(32'h00108033);
    chk("lit_x0dst_we", 32'(rd_we), 32'd0);
    chk("lit_x0dst_ill", 32'(illegal), 32'd0);
    wb(5'd0, 32'hFF);
    issue(32'h00000533);
    chk("lit_x0rd_a", rs1_val, 32'd0);
    chk("lit_x0rd_b", rs2_val, 32'd0);

    // reset while stalled, with a simultaneous writeback that must be lost
    issue(32'h003102B3);
    out_ready = 1'b0; in_valid = 1'b0;
    tick();
    rst = 1'b1; wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h55;
    tick();
    rst = 1'b0; wb_we = 1'b0;
    chk("lit_mrst_valid", 32'(out_valid), 32'd0);
    chk("lit_mrst_op", 32'(op_out), 32'd0);
    chk("lit_mrst_a", rs1_val, 32'd0);
    chk("lit_mrst_b", rs2_val, 32'd0);
    chk("lit_mrst_rd", 32'(rd_addr), 32'd0);
    chk("lit_mrst_ready", 32'(in_ready), 32'd1);
    issue(32'h000105B3);
    chk("lit_mrst_x2", rs1_val, 32'd0);
    in_valid = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rv_id_stage.md
# rv_id_stage

Instruction-decode stage that sits directly upstream of `rv_alu`. It accepts one 32-bit RV32I instruction per handshake and reads the integrated 32×32 register file. It latches the ALU opcode and both operands into a one-entry output register that drives `rv_alu` `op_in`/`rs1`/`rs2`. A writeback port from the downstream stage updates the register file and forwards into both the read path and the held operands.

## Interface
- `XLEN`, 32, data width; fixed at 32 for RV32I.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `instr` is valid.
- `in_ready`  out  1  stage can accept `instr` this cycle.
- `instr`  in  32  RV32I instruction word.
- `out_valid`  out  1  output register holds a decoded instruction.
- `out_ready`  in  1  the ALU/execute side takes the output this cycle.
- `op_out`  out  4  ALU opcode; connects to `rv_alu.op_in`.
- `rs1_val`  out  32  operand A; connects to `rv_alu.rs1`.
- `rs2_val`  out  32  operand B (register or immediate); connects to `rv_alu.rs2`.
- `rd_addr`  out  5  destination register.
- `rd_we`  out  1  destination is written.
- `illegal`  out  1  decoded instruction is unsupported.
- `wb_we`  in  1  writeback enable.
- `wb_addr`  in  5  writeback register.
- `wb_data`  in  32  writeback data.

## Operation
- **Opcode codes:** 0 NOP, 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR, 7 SRL, 8 SRA, 9 OR, 10 AND; 11–15 unused.
- **OP (0110011)**
  - funct3 selects the base op: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7 = 0100000 is legal only with funct3 000 (→SUB) or 101 (→SRA).
  - funct7 = 0000000 is legal for every funct3.
  - Any other funct7 is illegal.
  - Operand B = x[rs2].
- **OP-IMM (0010011)**
  - Same funct3 map; no SUB.
  - Operand B = sign-extended `instr[31:20]`.
  - For funct3 001/101: operand B = zero-extended `instr[24:20]`. `instr[31:25]` must be 0000000 (SLL/SRL) or 0100000 (SRA, funct3 101 only); otherwise illegal.
- **LUI (0110111)**
  - op ADD, operand A = 0, operand B = {`instr[31:12]`, 12'b0}.
- **Any other major opcode:** illegal.
- **Illegal instruction:** `op_out`=0, `rd_we`=0, `illegal`=1. Operands are don't-care. It still passes through the handshake.
- **`rd_we`:** 1 for legal instructions with rd≠0; 0 when rd=0.
- **Register file:** x0 always reads 0; writes to x0 are ignored. Reads are combinational from `instr` fields at accept time.
- **Read bypass:** if `wb_we` is set and `wb_addr` equals a source register (≠0) in the accept cycle, the operand takes `wb_data`.
- **Hold forwarding:** while `out_valid`=1 and `out_ready`=0, a writeback matching a held *register* source (≠0) replaces that held operand next cycle. Immediates and LUI operands are never replaced. Held source addresses are stored internally for this.
- **Flow control:** `in_ready` = !`out_valid` | `out_ready`.
  - Accept = `in_valid` & `in_ready`.
  - Accept loads the output register and sets `out_valid`.
  - `out_ready` without accept clears `out_valid`.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is valid on the outputs after edge N.
- Throughput is 1 instruction per cycle when `out_ready`=1.
- **Reset:** `out_valid`=0, `op_out`=0, `rs1_val`=0, `rs2_val`=0, `rd_addr`=0, `rd_we`=0, `illegal`=0, x1–x31=0. `in_ready`=1 immediately after reset.
- **Reset mid-operation:** the held instruction is dropped and a simultaneous writeback is discarded; the reset values above apply.
- **Stall:** outputs are stable while `out_valid`=1 and `out_ready`=0, except for hold forwarding.
- **Simultaneous accept and drain:** the new instruction replaces the old one in the same edge, with no bubble.
- **Register-file write:** `wb_*` writes the register file at the edge regardless of handshake state.

## Test plan
- **LUI reset/decode:** reset, then `instr`=0x00200093 (addi x1,x0,2) with `out_ready`=1 → next cycle `op_out`=1, `rs1_val`=0, `rs2_val`=2, `rd_addr`=1, `rd_we`=1. Then `instr`=0x123450B7 (lui x1) → `rs2_val`=0x12345000, `op_out`=1.
- **R-type with bypass:** write x2=5 and x3=7 via wb, then sub x4,x2,x3 (0x40310233) → `op_out`=2, `rs1_val`=5, `rs2_val`=7. Repeat with `wb_we` x3=9 in the accept cycle → `rs2_val`=9.
- **Stall and hold forwarding:** hold `out_ready`=0 with add x5,x2,x3 held → `in_ready`=0 and outputs stable. A wb x2=0xAA during the stall updates `rs1_val` to 0xAA next cycle. Then `out_ready`=1 → `out_valid` drops if `in_valid`=0.
- **Back-to-back:** 4 consecutive instructions with `in_valid`=`out_ready`=1 → one output per cycle, in order, no bubbles.
- **Illegal and x0:** `instr`=0x0000007F and srai with funct7 0000001 → `illegal`=1, `op_out`=0, `rd_we`=0. Then add x0,x1,x1 → `rd_we`=0. Then wb x0=0xFF followed by a read of x0 → 0.
- **Reset mid-stall:** assert `rst` with `out_valid`=1 → next cycle `out_valid`=0, all outputs 0, and a previously written x2 reads 0.
